bimodal_bht_part: RTL and testbench

Domain-partitioned bimodal branch predictor with direction and target storage. It is generalised in index width, counter width, domain count and target width. Explicit lookup and update ports carry their own index and domain. A per-domain flush sequencer clears one domain's partition without disturbing the others. Sits in the fetch-stage predictor, alongside or under the tagged tables.

---
 rtl/bimodal_bht_part_if.sv | 45 ++++
 rtl/bimodal_bht_part.sv | 148 ++++++++++++++
 tb/tb_bimodal_bht_part.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bimodal_bht_part_if.sv
// ============================================================================
// bimodal_bht_part_if : lookup, update and flush bundle for bimodal_bht_part
// Rev 1.0
// ============================================================================
`default_nettype none

interface bimodal_bht_part_if #(
  parameter int IDX_W  = 6,
  parameter int DOM_W  = 1,
  parameter int TARG_W = 32
);
  logic              lookup_valid_i;
  logic [IDX_W-1:0]  lookup_idx_i;
  logic [DOM_W-1:0]  lookup_dom_i;
  logic              pred_valid_o;
  logic              pred_taken_o;
  logic [TARG_W-1:0] pred_targ_o;
  logic              upd_en_i;
  logic [IDX_W-1:0]  upd_idx_i;
  logic [DOM_W-1:0]  upd_dom_i;
  logic              upd_taken_i;
  logic [TARG_W-1:0] upd_targ_i;
  logic              flush_req_i;
  logic [DOM_W-1:0]  flush_dom_i;
  logic              flush_busy_o;
  logic              flush_done_o;

  modport master (
    output lookup_valid_i, lookup_idx_i, lookup_dom_i,
    output upd_en_i, upd_idx_i, upd_dom_i, upd_taken_i, upd_targ_i,
    output flush_req_i, flush_dom_i,
    input  pred_valid_o, pred_taken_o, pred_targ_o,
    input  flush_busy_o, flush_done_o
  );

  modport slave (
    input  lookup_valid_i, lookup_idx_i, lookup_dom_i,
    input  upd_en_i, upd_idx_i, upd_dom_i, upd_taken_i, upd_targ_i,
    input  flush_req_i, flush_dom_i,
    output pred_valid_o, pred_taken_o, pred_targ_o,
    output flush_busy_o, flush_done_o
  );
endinterface

`default_nettype wire

// File: rtl/bimodal_bht_part.sv
// ============================================================================
// bimodal_bht_part : domain-partitioned bimodal direction/target predictor
// Rev 1.0
// ============================================================================
`default_nettype none

module bimodal_bht_part #(
  parameter int IDX_W   = 6,
  parameter int CTR_W   = 2,
  parameter int NUM_DOM = 2,
  parameter int DOM_W   = 1,
  parameter int TARG_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bimodal_bht_part_if.slave    bus
);

  localparam int               c_DEPTH   = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] c_CTR_MAX = '1;
  localparam logic [IDX_W-1:0] c_PTR_END = '1;
  localparam logic [DOM_W:0]   c_NUM_DOM = (DOM_W + 1)'(NUM_DOM);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CLEAR = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [DOM_W-1:0]  r_fdom;
  logic              w_busy;
  logic              w_done;
  logic              w_req_ok;

  logic [NUM_DOM-1:0] w_rd_taken;
  logic [TARG_W-1:0]  w_rd_targ [NUM_DOM];
  logic               w_sel_taken;
  logic [TARG_W-1:0]  w_sel_targ;

  logic               r_pred_valid;
  logic               r_pred_taken;
  logic [TARG_W-1:0]  r_pred_targ;

  assign w_req_ok = bus.flush_req_i && ({1'b0, bus.flush_dom_i} < c_NUM_DOM);

  // Flush sequencer: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_req_ok) w_state_nxt = c_ST_CLEAR;
      c_ST_CLEAR: if (r_ptr == c_PTR_END) w_state_nxt = c_ST_DONE;
      c_ST_DONE:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_ST_CLEAR);
    w_done = (r_state == c_ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_fdom <= '0;
    end else if (r_state == c_ST_IDLE && w_req_ok) begin
      r_ptr  <= '0;
      r_fdom <= bus.flush_dom_i;
    end else if (r_state == c_ST_CLEAR) begin
      r_ptr  <= r_ptr + IDX_W'(1);
    end
  end

  // One storage partition per domain; clear and update never meet in one partition
  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    logic [CTR_W-1:0]  r_ctr  [c_DEPTH];
    logic [TARG_W-1:0] r_targ [c_DEPTH];
    logic              w_clr;
    logic              w_upd;

    assign w_clr = w_busy && (r_fdom == DOM_W'(d));
    assign w_upd = bus.upd_en_i && (bus.upd_dom_i == DOM_W'(d)) && !w_clr;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < c_DEPTH; i++) begin
          r_ctr[i]  <= '0;
          r_targ[i] <= '0;
        end
      end else if (w_clr) begin
        r_ctr[r_ptr]  <= '0;
        r_targ[r_ptr] <= '0;
      end else if (w_upd) begin
        if (bus.upd_taken_i) begin
          if (r_ctr[bus.upd_idx_i] != c_CTR_MAX)
            r_ctr[bus.upd_idx_i] <= r_ctr[bus.upd_idx_i] + CTR_W'(1);
          r_targ[bus.upd_idx_i] <= bus.upd_targ_i;
        end else if (r_ctr[bus.upd_idx_i] != '0) begin
          r_ctr[bus.upd_idx_i] <= r_ctr[bus.upd_idx_i] - CTR_W'(1);
        end
      end
    end

    assign w_rd_taken[d] = r_ctr[bus.lookup_idx_i][CTR_W-1];
    assign w_rd_targ[d]  = r_targ[bus.lookup_idx_i];
  end

  // Illegal domains and the domain being flushed never match, so they read as zero
  always_comb begin
    w_sel_taken = 1'b0;
    w_sel_targ  = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (bus.lookup_dom_i == DOM_W'(d) && !(w_busy && r_fdom == DOM_W'(d))) begin
        w_sel_taken = w_rd_taken[d];
        w_sel_targ  = w_rd_targ[d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_targ  <= '0;
    end else begin
      r_pred_valid <= bus.lookup_valid_i;
      if (bus.lookup_valid_i) begin
        r_pred_taken <= w_sel_taken;
        r_pred_targ  <= w_sel_targ;
      end
    end
  end

  assign bus.pred_valid_o = r_pred_valid;
  assign bus.pred_taken_o = r_pred_taken;
  assign bus.pred_targ_o  = r_pred_targ;
  assign bus.flush_busy_o = w_busy;
  assign bus.flush_done_o = w_done;

endmodule

`default_nettype wire

// File: tb/tb_bimodal_bht_part.sv
// ============================================================================
// tb_bimodal_bht_part : directed + randomized bench with a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bimodal_bht_part;

  localparam int IDX_W   = 6;
  localparam int CTR_W   = 2;
  localparam int NUM_DOM = 2;
  localparam int DOM_W   = 2;
  localparam int TARG_W  = 32;
  localparam int DEPTH   = 2 ** IDX_W;
  localparam int CMAX    = 2 ** CTR_W - 1;
  localparam int CHALF   = 2 ** (CTR_W - 1);

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  bimodal_bht_part_if #(.IDX_W(IDX_W), .DOM_W(DOM_W), .TARG_W(TARG_W)) bus ();

  bimodal_bht_part #(
    .IDX_W(IDX_W), .CTR_W(CTR_W), .NUM_DOM(NUM_DOM), .DOM_W(DOM_W), .TARG_W(TARG_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of counter values and targets per domain
  int          m_ctr  [4][DEPTH];
  logic [31:0] m_targ [4][DEPTH];
  bit          m_busy, m_done;
  int          m_left, m_fdom;
  logic        e_valid, e_taken;
  logic [31:0] e_targ;

  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < DEPTH; i++) begin
        m_ctr[d][i]  = 0;
        m_targ[d][i] = '0;
      end
    m_busy = 0; m_done = 0; m_left = 0; m_fdom = 0;
    e_valid = 0; e_taken = 0; e_targ = '0;
  endtask

  task automatic model_step();
    int ld, li, ud, ui, fd;
    ld = int'(bus.lookup_dom_i); li = int'(bus.lookup_idx_i);
    ud = int'(bus.upd_dom_i);    ui = int'(bus.upd_idx_i);
    fd = int'(bus.flush_dom_i);
    e_valid = bus.lookup_valid_i;
    if (bus.lookup_valid_i) begin
      if (ld >= NUM_DOM || (m_busy && ld == m_fdom)) begin
        e_taken = 0; e_targ = '0;
      end else begin
        e_taken = (m_ctr[ld][li] >= CHALF);
        e_targ  = m_targ[ld][li];
      end
    end
    if (bus.upd_en_i && ud < NUM_DOM && !(m_busy && ud == m_fdom)) begin
      if (bus.upd_taken_i) begin
        m_ctr[ud][ui]  = (m_ctr[ud][ui] + 1 > CMAX) ? CMAX : m_ctr[ud][ui] + 1;
        m_targ[ud][ui] = bus.upd_targ_i;
      end else begin
        m_ctr[ud][ui] = (m_ctr[ud][ui] > 0) ? m_ctr[ud][ui] - 1 : 0;
      end
    end
    if (m_busy) begin
      m_ctr[m_fdom][DEPTH - m_left]  = 0;
      m_targ[m_fdom][DEPTH - m_left] = '0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.flush_req_i && fd < NUM_DOM) begin
      m_busy = 1; m_left = DEPTH; m_fdom = fd;
    end
  endtask

  task automatic check_outs();
    check_val("pred_valid", 32'(bus.pred_valid_o), 32'(e_valid));
    check_val("pred_taken", 32'(bus.pred_taken_o), 32'(e_taken));
    check_val("pred_targ",  bus.pred_targ_o,       e_targ);
    check_val("flush_busy", 32'(bus.flush_busy_o), 32'(m_busy));
    check_val("flush_done", 32'(bus.flush_done_o), 32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic in_idle();
    bus.lookup_valid_i = 0; bus.lookup_idx_i = '0; bus.lookup_dom_i = '0;
    bus.upd_en_i = 0; bus.upd_idx_i = '0; bus.upd_dom_i = '0;
    bus.upd_taken_i = 0; bus.upd_targ_i = '0;
    bus.flush_req_i = 0; bus.flush_dom_i = '0;
  endtask

  // Asserted mid-cycle: outputs must drop before any clock edge
  task automatic do_reset();
    in_idle();
    rst_i = 1'b1;
    #2;
    model_reset();
    check_outs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic set_upd(input int d, input int i, input bit t, input logic [31:0] tg);
    bus.upd_en_i = 1; bus.upd_dom_i = DOM_W'(d); bus.upd_idx_i = IDX_W'(i);
    bus.upd_taken_i = t; bus.upd_targ_i = tg;
  endtask

  task automatic set_look(input int d, input int i);
    bus.lookup_valid_i = 1; bus.lookup_dom_i = DOM_W'(d); bus.lookup_idx_i = IDX_W'(i);
  endtask

  task automatic op_upd(input int d, input int i, input bit t, input logic [31:0] tg);
    set_upd(d, i, t, tg); tick(); in_idle();
  endtask

  task automatic op_look(input int d, input int i);
    set_look(d, i); tick(); in_idle();
  endtask

  int busy_cnt, done_cnt, done_cyc;

  initial begin
    in_idle();
    rst_i = 1'b1;
    #3;
    do_reset();

    // Default read after reset
    op_look(0, 5);
    check_val("dflt_taken", 32'(bus.pred_taken_o), 32'd0);

    // Train, then reset asynchronously mid-cycle
    op_upd(0, 5, 1, 32'h55);
    op_upd(0, 5, 1, 32'h55);
    op_look(0, 5);
    do_reset();
    op_look(0, 5);

    // Saturation and target retention
    repeat (4) op_upd(1, 3, 1, 32'h1000);
    op_look(1, 3);
    check_val("sat_taken", 32'(bus.pred_taken_o), 32'd1);
    check_val("sat_targ",  bus.pred_targ_o, 32'h1000);
    op_upd(1, 3, 0, 32'h0);
    op_look(1, 3);
    repeat (2) op_upd(1, 3, 0, 32'h0);
    op_look(1, 3);
    check_val("dec_taken", 32'(bus.pred_taken_o), 32'd0);
    check_val("dec_targ",  bus.pred_targ_o, 32'h1000);

    // Read-before-write on the same entry
    repeat (3) begin
      set_look(1, 3); set_upd(1, 3, 1, 32'h2000); tick(); in_idle();
    end
    op_look(1, 3);

    // Isolation between domains
    repeat (2) op_upd(0, 7, 1, 32'hA0);
    op_look(1, 7);
    op_look(0, 7);
    check_val("iso_targ", bus.pred_targ_o, 32'hA0);

    // Illegal domain: no effect, reads zero, flush ignored
    repeat (3) op_upd(3, 7, 1, 32'hDEAD);
    op_look(3, 7);
    op_look(0, 7);
    bus.flush_req_i = 1; bus.flush_dom_i = DOM_W'(3); tick(); in_idle();
    repeat (3) tick();

    // Flush dom1 with concurrent traffic
    repeat (2) op_upd(1, 0, 1, 32'h11);
    repeat (2) op_upd(1, 63, 1, 32'h22);
    repeat (2) op_upd(0, 0, 1, 32'h33);
    bus.flush_req_i = 1; bus.flush_dom_i = DOM_W'(1); tick(); in_idle();
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 70; k++) begin
      if (bus.flush_busy_o) busy_cnt++;
      if (bus.flush_done_o) begin done_cnt++; done_cyc = k; end
      if (k == 5)  set_upd(1, 10, 1, 32'h77);
      if (k == 6)  set_upd(0, 10, 1, 32'h88);
      if (k == 7)  set_look(1, 10);
      if (k == 8)  set_look(1, 0);
      if (k == 10) begin bus.flush_req_i = 1; bus.flush_dom_i = DOM_W'(0); end
      tick(); in_idle();
    end
    check_val("busy_cycles", 32'(busy_cnt), 32'd64);
    check_val("done_pulses", 32'(done_cnt), 32'd1);
    check_val("done_cycle",  32'(done_cyc), 32'd65);
    op_look(1, 0);
    op_look(1, 63);
    op_look(0, 0);
    check_val("fl_keep_d0", 32'(bus.pred_taken_o), 32'd1);
    op_look(0, 10);
    op_look(1, 10);

    // Flush aborted by reset at ptr=20
    repeat (2) op_upd(1, 5, 1, 32'h99);
    bus.flush_req_i = 1; bus.flush_dom_i = DOM_W'(1); tick(); in_idle();
    repeat (20) tick();
    do_reset();
    done_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      if (bus.flush_done_o) done_cnt++;
      tick();
    end
    check_val("abort_done", 32'(done_cnt), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.lookup_valid_i = 1'($urandom_range(0, 1));
      bus.lookup_dom_i   = DOM_W'($urandom_range(0, 3));
      bus.lookup_idx_i   = IDX_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      bus.upd_en_i       = 1'($urandom_range(0, 1));
      bus.upd_dom_i      = DOM_W'($urandom_range(0, 3));
      bus.upd_idx_i      = IDX_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      bus.upd_taken_i    = 1'($urandom_range(0, 1));
      bus.upd_targ_i     = $urandom;
      bus.flush_req_i    = (!m_busy && !m_done && $urandom_range(0, 149) == 0);
      bus.flush_dom_i    = DOM_W'($urandom_range(0, 3));
      tick();
    end
    in_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
